axi_clkgen_reconfig_seq: RTL and testbench
==========================================

AXI_CLKGEN_RECONFIG_SEQ -- requirements
Module: axi_clkgen_reconfig_seq

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of DRP table entries, 1..16.
REQ-002 SHALL have parameter POLL_LIMIT, default 1024: maximum read polls per wait phase before timeout.
REQ-003 SHALL have ports `clk` (input, 1, single clock) and `resetn` (input, 1, reset, asynchronous, active-low).
REQ-004 SHALL have port `start` (input, 1): one-cycle pulse that launches a sequence; ignored while busy.
REQ-005 SHALL have ports `tbl_idx` (output, 4) and `tbl_data` (input, 44): table lookup with combinational return.
  - `tbl_data` = {drp_addr[11:0], mask[15:0], value[15:0]}.
REQ-006 SHALL have ports `up_wreq` (output, 1), `up_waddr` (output, 14), `up_wdata` (output, 32), `up_wack` (input, 1): register write master.
REQ-007 SHALL have ports `up_rreq` (output, 1), `up_raddr` (output, 14), `up_rdata` (input, 32), `up_rack` (input, 1): register read master.
REQ-008 SHALL have ports `busy` (output, 1), `done` (output, 1, one-cycle pulse), `error` (output, 1, sticky), `err_code` (output, 2).

Function
REQ-009 SHALL use these word addresses:
  - RSTN = 0x010, {MMCM_RSTN, RSTN} in bits [1:0].
  - DRP_CNTRL = 0x01C, RWN bit 28, ADDRESS bits [27:16], WDATA bits [15:0].
  - DRP_STATUS = 0x01D, LOCKED bit 17, BUSY bit 16, RDATA bits [15:0].
REQ-010 SHALL step through states IDLE -> MRST -> (RD_REQ -> RD_POLL ->) WR_REQ -> WR_POLL -> NEXT -> MREL -> LOCK_POLL -> IDLE, with ERR -> IDLE.
REQ-011 SHALL hold each request (`up_wreq`/`up_rreq`) high with stable address and data until the matching ack is sampled high; only one request may be outstanding at a time.
REQ-012 SHALL, in MRST, write 0x1 to RSTN: MMCM held in reset, RSTN released.
REQ-013 SHALL, in RD_REQ, write DRP_CNTRL = {RWN=1, drp_addr, 0}.
REQ-014 SHALL, in RD_POLL, repeatedly read DRP_STATUS until BUSY = 0, then latch RDATA.
REQ-015 SHALL, in WR_REQ, write DRP_CNTRL = {RWN=0, drp_addr, (rdata & ~mask) | (value & mask)}.
REQ-016 SHALL, in WR_POLL, repeatedly read DRP_STATUS until BUSY = 0.
REQ-017 SHALL, in NEXT, increment `tbl_idx`, return to the DRP phase while `tbl_idx` < NUM_ENTRIES, else go to MREL.
REQ-018 SHALL, in MREL, write 0x3 to RSTN.
REQ-019 SHALL, in LOCK_POLL, read DRP_STATUS until LOCKED = 1, then pulse `done` for one cycle and return to IDLE.
REQ-020 SHALL count reads per poll phase with a counter cleared on phase entry; when the count reaches POLL_LIMIT with the condition unmet, SHALL enter ERR.
  - `err_code` = 1 for a DRP timeout, 2 for a lock timeout.
REQ-021 SHALL, in ERR, write 0x3 to RSTN (best effort), set `error`, skip `done`, and return to IDLE.
REQ-022 SHALL clear `error` and `err_code` on an accepted `start`.
REQ-023 SHALL drive `busy` = 1 in every state except IDLE; a `start` arriving in the same cycle as `done` SHALL be ignored.
REQ-024 SHALL use `tbl_data` sampled in the same cycle the request carrying it is first issued, held registered thereafter.

Reset
REQ-025 SHALL, on `resetn` low, asynchronously force state IDLE, all outputs 0, `tbl_idx` = 0, and poll counter = 0.
REQ-026 SHALL abandon any in-flight sequence when reset asserts mid-operation, drop any pending request immediately, and issue no further bus cycles.

Configuration
REQ-027 SHALL support macro AXI_CLKGEN_RECONFIG_SEQ_RMW_EN:
  - Defined: RD_REQ and RD_POLL are executed (read-modify-write).
  - Undefined: NEXT/MRST go directly to WR_REQ, WDATA = value & mask, and rdata is unused.

Verification
REQ-028 Bench SHALL cover a 1-entry table {0x008, 0x0FFF, 0x0041} with DRP rdata 0x1234 (RMW_EN defined) -> writes in order:
  - RSTN 0x1;
  - DRP_CNTRL 0x10080000;
  - DRP_CNTRL 0x00081041;
  - RSTN 0x3;
  - then `done` pulses once.
REQ-029 Bench SHALL cover BUSY held 1 for 1024 polls -> ERR, `err_code` = 1, RSTN written 0x3, `error` = 1, no `done`.
REQ-030 Bench SHALL cover LOCKED never set -> `err_code` = 2 after exactly POLL_LIMIT reads of DRP_STATUS.
REQ-031 Bench SHALL cover `resetn` low during WR_POLL with `up_rreq` high -> next cycle all outputs 0 and `busy` = 0; a subsequent `start` runs the full sequence from entry 0.
REQ-032 Bench SHALL cover RMW_EN undefined with the same table as REQ-028 -> no DRP read request and WDATA = 0x0041.
REQ-033 Bench SHALL cover `start` pulses issued while busy and in the `done` cycle -> ignored, exactly one sequence executed.

Source files
------------

// File: rtl/axi_clkgen_reconfig_seq.sv
// axi_clkgen_reconfig_seq: walks a DRP table into the MMCM over the up_* register bus.
// Define AXI_CLKGEN_RECONFIG_SEQ_RMW_EN to read-modify-write each DRP register.
module axi_clkgen_reconfig_seq #(
  parameter int NUM_ENTRIES = 8,
  parameter int POLL_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [3:0]  tbl_idx,
  input  logic [43:0] tbl_data,
  output logic        up_wreq,
  output logic [13:0] up_waddr,
  output logic [31:0] up_wdata,
  input  logic        up_wack,
  output logic        up_rreq,
  output logic [13:0] up_raddr,
  input  logic [31:0] up_rdata,
  input  logic        up_rack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);
`ifdef AXI_CLKGEN_RECONFIG_SEQ_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [13:0] A_RSTN = 14'h010, A_CNTRL = 14'h01C, A_STATUS = 14'h01D;
  typedef enum logic [3:0] {IDLE, MRST, RD_REQ, RD_POLL, WR_REQ, WR_POLL, NEXT, MREL, LOCK_POLL, ERR} state_t;
  localparam state_t DRP_ENTRY = RMW ? RD_REQ : WR_REQ;
  state_t state_q;
  logic [3:0] idx_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] rdata_q, mask, value, merged;
  logic [11:0] drp_addr;
  logic wreq_q, rreq_q, done_q, error_q, last, poll_out;
  logic [13:0] waddr_q, raddr_q;
  logic [31:0] wdata_q;
  logic [1:0] err_q;
  logic unused_rdata;
  assign {drp_addr, mask, value} = tbl_data;
  assign merged = RMW ? (rdata_q & ~mask) | (value & mask) : value & mask;
  assign cnt_d = cnt_q + 1'b1;
  assign poll_out = cnt_d == CW'(POLL_LIMIT);
  assign last = ({1'b0, idx_q} + 5'd1) >= 5'(NUM_ENTRIES);
  assign unused_rdata = ^up_rdata[31:18];
  assign tbl_idx = idx_q;
  assign up_wreq = wreq_q;
  assign up_waddr = waddr_q;
  assign up_wdata = wdata_q;
  assign up_rreq = rreq_q;
  assign up_raddr = raddr_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign error = error_q;
  assign err_code = err_q;
  // Each bus state issues its request when none is pending, then advances on the ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      wreq_q <= 1'b0;
      rreq_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      err_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start && !done_q) begin
          error_q <= 1'b0;
          err_q <= '0;
          idx_q <= '0;
          state_q <= MRST;
        end
        MRST: if (!wreq_q) begin
          wreq_q <= 1'b1;
          waddr_q <= A_RSTN;
          wdata_q <= 32'h1;
        end else if (up_wack) begin
          wreq_q <= 1'b0;
          state_q <= DRP_ENTRY;
        end
        RD_REQ: if (!wreq_q) begin
          wreq_q <= 1'b1;
          waddr_q <= A_CNTRL;
          wdata_q <= {3'b000, 1'b1, drp_addr, 16'h0};
        end else if (up_wack) begin
          wreq_q <= 1'b0;
          cnt_q <= '0;
          state_q <= RD_POLL;
        end
        RD_POLL: if (!rreq_q) begin
          rreq_q <= 1'b1;
          raddr_q <= A_STATUS;
        end else if (up_rack) begin
          rreq_q <= 1'b0;
          cnt_q <= cnt_d;
          if (!up_rdata[16]) begin
            rdata_q <= up_rdata[15:0];
            state_q <= WR_REQ;
          end else if (poll_out) begin
            err_q <= 2'd1;
            error_q <= 1'b1;
            state_q <= ERR;
          end
        end
        WR_REQ: if (!wreq_q) begin
          wreq_q <= 1'b1;
          waddr_q <= A_CNTRL;
          wdata_q <= {3'b000, 1'b0, drp_addr, merged};
        end else if (up_wack) begin
          wreq_q <= 1'b0;
          cnt_q <= '0;
          state_q <= WR_POLL;
        end
        WR_POLL: if (!rreq_q) begin
          rreq_q <= 1'b1;
          raddr_q <= A_STATUS;
        end else if (up_rack) begin
          rreq_q <= 1'b0;
          cnt_q <= cnt_d;
          if (!up_rdata[16]) state_q <= NEXT;
          else if (poll_out) begin
            err_q <= 2'd1;
            error_q <= 1'b1;
            state_q <= ERR;
          end
        end
        NEXT: begin
          idx_q <= idx_q + 4'd1;
          state_q <= last ? MREL : DRP_ENTRY;
        end
        MREL: if (!wreq_q) begin
          wreq_q <= 1'b1;
          waddr_q <= A_RSTN;
          wdata_q <= 32'h3;
        end else if (up_wack) begin
          wreq_q <= 1'b0;
          cnt_q <= '0;
          state_q <= LOCK_POLL;
        end
        LOCK_POLL: if (!rreq_q) begin
          rreq_q <= 1'b1;
          raddr_q <= A_STATUS;
        end else if (up_rack) begin
          rreq_q <= 1'b0;
          cnt_q <= cnt_d;
          if (up_rdata[17]) begin
            done_q <= 1'b1;
            state_q <= IDLE;
          end else if (poll_out) begin
            err_q <= 2'd2;
            error_q <= 1'b1;
            state_q <= ERR;
          end
        end
        ERR: if (!wreq_q) begin
          wreq_q <= 1'b1;
          waddr_q <= A_RSTN;
          wdata_q <= 32'h3;
        end else if (up_wack) begin
          wreq_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_clkgen_reconfig_seq.sv
// tb_axi_clkgen_reconfig_seq: bus/DRP device model plus a table-level reference of the expected write stream.
module tb_axi_clkgen_reconfig_seq;
`ifdef AXI_CLKGEN_RECONFIG_SEQ_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  localparam int PL_A = 1024, PL_B = 16, NB = 4;
  localparam logic [13:0] A_RSTN = 14'h010, A_CNTRL = 14'h01C, A_STATUS = 14'h01D;
  typedef struct {logic [13:0] a; logic [31:0] d; int rd;} wr_t;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, sel = 1'b0;
  always #5 clk = ~clk;
  logic [43:0] tbl [16];
  logic [3:0] idx_a, idx_b, tbl_idx;
  logic [43:0] td_a, td_b;
  logic wreq_a, wreq_b, rreq_a, rreq_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [13:0] waddr_a, waddr_b, raddr_a, raddr_b, waddr, raddr;
  logic [31:0] wdata_a, wdata_b, wdata, rdata;
  logic [1:0] ec_a, ec_b, err_code;
  logic wack, rack, wreq, rreq, busy, done, error;
  assign td_a = tbl[idx_a];
  assign td_b = tbl[idx_b];
  assign wreq = sel ? wreq_b : wreq_a;
  assign rreq = sel ? rreq_b : rreq_a;
  assign waddr = sel ? waddr_b : waddr_a;
  assign raddr = sel ? raddr_b : raddr_a;
  assign wdata = sel ? wdata_b : wdata_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign error = sel ? err_b : err_a;
  assign err_code = sel ? ec_b : ec_a;
  assign tbl_idx = sel ? idx_b : idx_a;

  axi_clkgen_reconfig_seq #(.NUM_ENTRIES(1), .POLL_LIMIT(PL_A)) dut_a (
    .clk(clk), .resetn(resetn), .start(start && !sel), .tbl_idx(idx_a), .tbl_data(td_a),
    .up_wreq(wreq_a), .up_waddr(waddr_a), .up_wdata(wdata_a), .up_wack(wack && !sel),
    .up_rreq(rreq_a), .up_raddr(raddr_a), .up_rdata(rdata), .up_rack(rack && !sel),
    .busy(busy_a), .done(done_a), .error(err_a), .err_code(ec_a));
  axi_clkgen_reconfig_seq #(.NUM_ENTRIES(NB), .POLL_LIMIT(PL_B)) dut_b (
    .clk(clk), .resetn(resetn), .start(start && sel), .tbl_idx(idx_b), .tbl_data(td_b),
    .up_wreq(wreq_b), .up_waddr(waddr_b), .up_wdata(wdata_b), .up_wack(wack && sel),
    .up_rreq(rreq_b), .up_raddr(raddr_b), .up_rdata(rdata), .up_rack(rack && sel),
    .busy(busy_b), .done(done_b), .error(err_b), .err_code(ec_b));

  logic stuck = 1'b0, lock_ok = 1'b1, drp_load = 1'b0;
  int busy_polls = 0, lock_delay = 0, ack_max = 0;
  logic [15:0] drp_init [16], drp_mem [16], exp_mem [16];
  logic [3:0] rd_addr = '0;
  int rd_since_wr = 0, done_cnt = 0, proto_err = 0, wdly = 0, rdly = 0;
  logic wreq_p = 1'b0, rreq_p = 1'b0, wack_p = 1'b0, rack_p = 1'b0;
  logic [13:0] waddr_p = '0;
  logic [31:0] wdata_p = '0;
  wr_t wlog[$], exp[$];
  int n_chk = 0, n_pass = 0;

  // Register slave with random ack latency, a 16-word DRP array and BUSY/LOCKED behaviour.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wack <= 1'b0;
      rack <= 1'b0;
      wdly <= 0;
      rdly <= 0;
      wreq_p <= 1'b0;
      rreq_p <= 1'b0;
    end else begin
      wack <= 1'b0;
      rack <= 1'b0;
      if (drp_load) for (int k = 0; k < 16; k++) drp_mem[k] <= drp_init[k];
      if (done) done_cnt <= done_cnt + 1;
      if (wreq && !wack) begin
        if (wdly == 0) begin
          wack <= 1'b1;
          wlog.push_back(wr_t'{waddr, wdata, rd_since_wr});
          rd_since_wr <= 0;
          wdly <= $urandom_range(0, ack_max);
          if (waddr == A_CNTRL) begin
            if (wdata[28]) rd_addr <= wdata[19:16];
            else drp_mem[wdata[19:16]] <= wdata[15:0];
          end
        end else wdly <= wdly - 1;
      end
      if (rreq && !rack) begin
        if (rdly == 0) begin
          rack <= 1'b1;
          rd_since_wr <= rd_since_wr + 1;
          rdata <= {14'b0, lock_ok && rd_since_wr >= lock_delay, stuck || rd_since_wr < busy_polls, drp_mem[rd_addr]};
          rdly <= $urandom_range(0, ack_max);
        end else rdly <= rdly - 1;
      end
      if (wreq_p && !wack_p && (!wreq || waddr !== waddr_p || wdata !== wdata_p)) proto_err <= proto_err + 1;
      if (rreq_p && !rack_p && !rreq) proto_err <= proto_err + 1;
      if ((wreq && rreq) || (rreq && raddr !== A_STATUS)) proto_err <= proto_err + 1;
      wreq_p <= wreq;
      rreq_p <= rreq;
      wack_p <= wack;
      rack_p <= rack;
      waddr_p <= waddr;
      wdata_p <= wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_drp();
    drp_load = 1'b1;
    tick();
    drp_load = 1'b0;
    for (int k = 0; k < 16; k++) exp_mem[k] = drp_init[k];
  endtask

  task automatic run_seq(output bit ok);
    ok = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      tick();
      ok = !busy;
    end
    tick();
    tick();
  endtask

  // Expected write stream for an n-entry table, applied to a copy of the DRP contents.
  task automatic model_seq(input int n);
    logic [11:0] a;
    logic [15:0] m, v, nv;
    exp.delete();
    exp.push_back(wr_t'{A_RSTN, 32'h1, 0});
    for (int i = 0; i < n; i++) begin
      {a, m, v} = tbl[i];
      if (RMW) exp.push_back(wr_t'{A_CNTRL, 32'h1000_0000 + 32'(a) * 65536, 0});
      nv = RMW ? (exp_mem[a[3:0]] & ~m) | (v & m) : (v & m);
      exp.push_back(wr_t'{A_CNTRL, 32'(a) * 65536 + 32'(nv), 0});
      exp_mem[a[3:0]] = nv;
    end
    exp.push_back(wr_t'{A_RSTN, 32'h3, 0});
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({wreq_a, rreq_a, busy_a, done_a, err_a, ec_a, idx_a, waddr_a, wdata_a, raddr_a} !== '0)
      $display("FAIL reset_a: got %b/%b/%b/%b/%b/%h/%h/%h/%h/%h want all 0", wreq_a, rreq_a, busy_a, done_a, err_a, ec_a, idx_a, waddr_a, wdata_a, raddr_a);
    else n_pass++;
    n_chk++;
    if ({wreq_b, rreq_b, busy_b, done_b, err_b, ec_b, idx_b, waddr_b, wdata_b, raddr_b} !== '0)
      $display("FAIL reset_b: got %b/%b/%b/%b/%b/%h/%h/%h/%h/%h want all 0", wreq_b, rreq_b, busy_b, done_b, err_b, ec_b, idx_b, waddr_b, wdata_b, raddr_b);
    else n_pass++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    bit ok;
    int base, d0, n;
    logic [13:0] ea [4];
    logic [31:0] ed [4];
    if (RMW) begin
      n = 4;
      ea = '{A_RSTN, A_CNTRL, A_CNTRL, A_RSTN};
      ed = '{32'h1, 32'h1008_0000, 32'h0008_1041, 32'h3};
    end else begin
      n = 3;
      ea = '{A_RSTN, A_CNTRL, A_RSTN, A_RSTN};
      ed = '{32'h1, 32'h0008_0041, 32'h3, 32'h3};
    end
    sel = 1'b0;
    tbl[0] = {12'h008, 16'h0FFF, 16'h0041};
    drp_init[8] = 16'h1234;
    load_drp();
    stuck = 1'b0; lock_ok = 1'b1; busy_polls = 2; lock_delay = 3; ack_max = 2;
    base = wlog.size();
    d0 = done_cnt;
    run_seq(ok);
    n_chk++;
    if (!ok) $display("FAIL dir_timeout: busy still %b want 0", busy); else n_pass++;
    n_chk++;
    if (wlog.size() - base != n) $display("FAIL dir_count: got %0d writes want %0d", wlog.size() - base, n); else n_pass++;
    for (int k = 0; k < n && base + k < wlog.size(); k++) begin
      n_chk++;
      if (wlog[base + k].a !== ea[k] || wlog[base + k].d !== ed[k])
        $display("FAIL dir_write[%0d]: got %h:%h want %h:%h", k, wlog[base + k].a, wlog[base + k].d, ea[k], ed[k]);
      else n_pass++;
    end
    n_chk++;
    if (wlog.size() - base == n && wlog[$].rd != busy_polls + 1)
      $display("FAIL dir_wr_polls: got %0d want %0d", wlog[$].rd, busy_polls + 1);
    else n_pass++;
    n_chk++;
    if (done_cnt - d0 != 1 || error !== 1'b0) $display("FAIL dir_done: got done %0d error %b want 1/0", done_cnt - d0, error); else n_pass++;
  endtask

  task automatic test_drp_timeout();
    bit ok;
    int base, d0;
    sel = 1'b0;
    stuck = 1'b1; ack_max = 0;
    base = wlog.size();
    d0 = done_cnt;
    run_seq(ok);
    n_chk++;
    if (!ok || err_code !== 2'd1 || error !== 1'b1) $display("FAIL drp_to_err: got ok %b code %0d error %b want 1/1/1", ok, err_code, error); else n_pass++;
    n_chk++;
    if (wlog.size() - base != 3 || wlog[$].a !== A_RSTN || wlog[$].d !== 32'h3 || wlog[$].rd != PL_A)
      $display("FAIL drp_to_log: got %0d writes last %h:%h after %0d polls want 3 writes 010:3 after %0d", wlog.size() - base, wlog[$].a, wlog[$].d, wlog[$].rd, PL_A);
    else n_pass++;
    n_chk++;
    if (done_cnt != d0 || busy !== 1'b0) $display("FAIL drp_to_done: got done %0d busy %b want 0/0", done_cnt - d0, busy); else n_pass++;
    stuck = 1'b0;
  endtask

  task automatic test_lock_timeout();
    bit ok;
    int base, d0;
    sel = 1'b0;
    lock_ok = 1'b0; busy_polls = 0; ack_max = 0;
    base = wlog.size();
    d0 = done_cnt;
    run_seq(ok);
    n_chk++;
    if (!ok || err_code !== 2'd2 || error !== 1'b1) $display("FAIL lock_to_err: got ok %b code %0d error %b want 1/2/1", ok, err_code, error); else n_pass++;
    n_chk++;
    if (wlog.size() - base < 2 || wlog[$].rd != PL_A || wlog[$].d !== 32'h3 || wlog[wlog.size() - 2].d !== 32'h3)
      $display("FAIL lock_to_polls: got %0d polls last %h want %0d polls after two RSTN=3 writes", wlog[$].rd, wlog[$].d, PL_A);
    else n_pass++;
    n_chk++;
    if (done_cnt != d0) $display("FAIL lock_to_done: got %0d done pulses want 0", done_cnt - d0); else n_pass++;
    lock_ok = 1'b1;
  endtask

  task automatic test_ignore_start();
    bit got;
    int base, d0;
    sel = 1'b0;
    busy_polls = 1; lock_delay = 1; ack_max = 1;
    load_drp();
    model_seq(1);
    base = wlog.size();
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) $display("FAIL start_clear: got error %b code %0d busy %b want 0/0/1", error, err_code, busy); else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      start = (i == 3) || (i == 7);
      tick();
      got = done;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    n_chk++;
    if (!got || busy !== 1'b0 || done_cnt - d0 != 1) $display("FAIL ignore_start: got done %b busy %b pulses %0d want 1/0/1", got, busy, done_cnt - d0); else n_pass++;
    n_chk++;
    if (wlog.size() - base != exp.size()) $display("FAIL ignore_count: got %0d writes want %0d", wlog.size() - base, exp.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    int base, sz;
    sel = 1'b0;
    busy_polls = 40; lock_delay = 0; ack_max = 1;
    load_drp();
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    base = wlog.size();
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      hit = wlog.size() > base && wlog[$].a == A_CNTRL && !wlog[$].d[28] && rreq;
    end
    n_chk++;
    if (!hit) $display("FAIL mid_reach: got no WR_POLL read want one"); else n_pass++;
    resetn = 1'b0;
    tick();
    n_chk++;
    if ({wreq, rreq, busy, done, error, err_code, tbl_idx, waddr, wdata, raddr} !== '0)
      $display("FAIL mid_reset: got %b/%b/%b/%b/%b/%h/%h/%h/%h/%h want all 0", wreq, rreq, busy, done, error, err_code, tbl_idx, waddr, wdata, raddr);
    else n_pass++;
    sz = wlog.size();
    tick();
    resetn = 1'b1;
    repeat (10) tick();
    n_chk++;
    if (wlog.size() != sz || busy !== 1'b0) $display("FAIL mid_quiet: got %0d new writes busy %b want 0/0", wlog.size() - sz, busy); else n_pass++;
    busy_polls = 1;
    load_drp();
    model_seq(1);
    base = wlog.size();
    run_seq(ok);
    n_chk++;
    if (!ok || wlog.size() - base != exp.size()) $display("FAIL mid_rerun: got ok %b %0d writes want 1/%0d", ok, wlog.size() - base, exp.size()); else n_pass++;
    for (int k = 0; k < exp.size() && base + k < wlog.size(); k++) begin
      n_chk++;
      if (wlog[base + k].a !== exp[k].a || wlog[base + k].d !== exp[k].d)
        $display("FAIL mid_write[%0d]: got %h:%h want %h:%h", k, wlog[base + k].a, wlog[base + k].d, exp[k].a, exp[k].d);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok;
    int base, d0;
    sel = 1'b1;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < NB; i++) tbl[i] = {12'($urandom_range(0, 15)), 16'($urandom), 16'($urandom)};
      for (int k = 0; k < 16; k++) drp_init[k] = 16'($urandom);
      load_drp();
      busy_polls = $urandom_range(0, 3); lock_delay = $urandom_range(0, 4); ack_max = $urandom_range(0, 2);
      model_seq(NB);
      base = wlog.size();
      d0 = done_cnt;
      run_seq(ok);
      n_chk++;
      if (!ok || done_cnt - d0 != 1 || error !== 1'b0) $display("FAIL rand_done[%0d]: got ok %b pulses %0d error %b want 1/1/0", it, ok, done_cnt - d0, error); else n_pass++;
      n_chk++;
      if (wlog.size() - base != exp.size()) $display("FAIL rand_count[%0d]: got %0d writes want %0d", it, wlog.size() - base, exp.size()); else n_pass++;
      for (int k = 0; k < exp.size() && base + k < wlog.size(); k++) begin
        n_chk++;
        if (wlog[base + k].a !== exp[k].a || wlog[base + k].d !== exp[k].d)
          $display("FAIL rand_write[%0d.%0d]: got %h:%h want %h:%h", it, k, wlog[base + k].a, wlog[base + k].d, exp[k].a, exp[k].d);
        else n_pass++;
      end
      for (int k = 0; k < 16; k++) begin
        n_chk++;
        if (drp_mem[k] !== exp_mem[k]) $display("FAIL rand_drp[%0d.%0d]: got %h want %h", it, k, drp_mem[k], exp_mem[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_b_timeout();
    bit ok;
    sel = 1'b1;
    lock_ok = 1'b0; busy_polls = 0; ack_max = 0;
    run_seq(ok);
    n_chk++;
    if (!ok || err_code !== 2'd2 || wlog[$].rd != PL_B) $display("FAIL b_lock_to: got ok %b code %0d polls %0d want 1/2/%0d", ok, err_code, wlog[$].rd, PL_B); else n_pass++;
    lock_ok = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      tbl[k] = '0;
      drp_init[k] = '0;
    end
    test_reset();
    test_directed();
    test_drp_timeout();
    test_lock_timeout();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_b_timeout();
    n_chk++;
    if (proto_err != 0) $display("FAIL protocol: got %0d handshake violations want 0", proto_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
